// File: rtl/fetch_queue.sv
// Dual-issue fetch queue: 0-2 pushes and 0-2 retires per cycle, zero-latency read of the oldest pair.
// Backpressure: push_ready drops once fewer than two entries are free; a push while not ready is dropped.
module fetch_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [1:0]                 push_valid,
  input  logic [INSTR_WIDTH-1:0]     push_instr0,
  input  logic [INSTR_WIDTH-1:0]     push_instr1,
  input  logic [PC_WIDTH-1:0]        push_pc0,
  input  logic [PC_WIDTH-1:0]        push_pc1,
  output logic                       push_ready,
  input  logic                       stall,
  input  logic                       issue_one,
  output logic [1:0]                 out_valid,
  output logic [INSTR_WIDTH-1:0]     out_instr0,
  output logic [INSTR_WIDTH-1:0]     out_instr1,
  output logic [PC_WIDTH-1:0]        out_pc0,
  output logic [PC_WIDTH-1:0]        out_pc1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [INSTR_WIDTH-1:0] r_instr [DEPTH];
  logic [PC_WIDTH-1:0]    r_pc    [DEPTH];
  logic [AW-1:0]          r_head;
  logic [AW-1:0]          r_tail;
  logic [CW-1:0]          r_count;

  logic [1:0]    w_pv;
  logic          w_do_push;
  logic [CW-1:0] w_n_push;
  logic [CW-1:0] w_n_pop;
  logic [AW-1:0] w_head1;

  assign push_ready = (r_count <= READY_MAX);
  assign count      = r_count;
  assign w_head1    = r_head + AW'(1);

  // 2'b10 is an illegal pattern and is treated as no push at all.
  assign w_pv      = (push_valid == 2'b10) ? 2'b00 : push_valid;
  assign w_do_push = push_ready && !flush;

  always_comb begin
    w_n_push = '0;
    if (w_do_push) begin
      w_n_push = CW'(w_pv[0]) + CW'(w_pv[1]);
    end
    w_n_pop = '0;
    if (!flush && !stall) begin
      if (issue_one) begin
        w_n_pop = (r_count >= CW'(1)) ? CW'(1) : '0;
      end else begin
        w_n_pop = (r_count >= CW'(2)) ? CW'(2) : r_count;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_n_pop[AW-1:0];
      r_tail  <= r_tail + w_n_push[AW-1:0];
      r_count <= r_count + w_n_push - w_n_pop;
    end
  end

  // Storage is never cleared; validity comes only from r_count.
  always_ff @(posedge clk) begin
    if (!rst && w_do_push) begin
      if (w_pv[0]) begin
        r_instr[r_tail] <= push_instr0;
        r_pc[r_tail]    <= push_pc0;
      end
      if (w_pv[1]) begin
        r_instr[r_tail + AW'(1)] <= push_instr1;
        r_pc[r_tail + AW'(1)]    <= push_pc1;
      end
    end
  end

  assign out_valid  = {(r_count >= CW'(2)), (r_count != '0)};
  assign out_instr0 = out_valid[0] ? r_instr[r_head]  : '0;
  assign out_pc0    = out_valid[0] ? r_pc[r_head]     : '0;
  assign out_instr1 = out_valid[1] ? r_instr[w_head1] : '0;
  assign out_pc1    = out_valid[1] ? r_pc[w_head1]    : '0;

  a_legal_push_valid: assert property (@(posedge clk) disable iff (rst) push_valid != 2'b10);
  a_push_when_ready:  assert property (@(posedge clk) disable iff (rst)
                                       (push_valid != 2'b00 && !flush) |-> push_ready);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/drain, single issue, wrap, flush and a scoreboarded steady stream.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  push_valid;
  logic [31:0] push_instr0, push_instr1, push_pc0, push_pc1;
  logic        push_ready;
  logic        stall, issue_one;
  logic [1:0]  out_valid;
  logic [31:0] out_instr0, out_instr1, out_pc0, out_pc1;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_q[$];

  fetch_queue #(.INSTR_WIDTH(32), .PC_WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_instr0(push_instr0), .push_instr1(push_instr1),
    .push_pc0(push_pc0), .push_pc1(push_pc1), .push_ready(push_ready),
    .stall(stall), .issue_one(issue_one),
    .out_valid(out_valid), .out_instr0(out_instr0), .out_instr1(out_instr1),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] pv, input logic [31:0] pc0, input logic [31:0] pc1);
    push_valid  = pv;
    push_pc0    = pc0;
    push_pc1    = pc1;
    push_instr0 = pc0 + 32'h1;
    push_instr1 = pc1 + 32'h1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; issue_one = 1'b0;
    push(2'b11, 32'h9000, 32'h9004);

    // T1 reset with pushes requested
    tick(); tick();
    rst = 1'b0;
    push(2'b00, 32'h0, 32'h0);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_valid", 64'(out_valid), 64'd0);
    chk("t1_instr0", 64'(out_instr0), 64'd0);
    chk("t1_ready", 64'(push_ready), 64'd1);

    // T2 fill while stalled, then drain two per cycle
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(2'b11, 32'h1000 + 32'(8 * k), 32'h1004 + 32'(8 * k));
      push_instr0 = 32'h13;
      push_instr1 = 32'h93;
      tick();
      if (k == 2) chk("t2_ready_at6", 64'(push_ready), 64'd1);
    end
    push(2'b00, 32'h0, 32'h0);
    chk("t2_full_count", 64'(count), 64'd8);
    chk("t2_full_ready", 64'(push_ready), 64'd0);
    chk("t2_full_instr0", 64'(out_instr0), 64'h13);
    chk("t2_full_instr1", 64'(out_instr1), 64'h93);
    chk("t2_full_pc1", 64'(out_pc1), 64'h1004);
    stall = 1'b0;
    tick();
    chk("t2_cnt6", 64'(count), 64'd6);
    chk("t2_pc0_6", 64'(out_pc0), 64'h1008);
    tick();
    chk("t2_cnt4", 64'(count), 64'd4);
    chk("t2_pc0_4", 64'(out_pc0), 64'h1010);
    tick();
    chk("t2_cnt2", 64'(count), 64'd2);
    chk("t2_pc1_2", 64'(out_pc1), 64'h101c);
    tick();
    chk("t2_cnt0", 64'(count), 64'd0);
    chk("t2_valid0", 64'(out_valid), 64'd0);
    chk("t2_pc0_empty", 64'(out_pc0), 64'd0);

    // count = DEPTH-1 boundary, then drain (head ends at 7)
    stall = 1'b1;
    push(2'b11, 32'h100, 32'h104); tick();
    push(2'b11, 32'h108, 32'h10c); tick();
    push(2'b11, 32'h110, 32'h114); tick();
    push(2'b01, 32'h118, 32'h0);   tick();
    push(2'b00, 32'h0, 32'h0);
    chk("b7_count", 64'(count), 64'd7);
    chk("b7_ready", 64'(push_ready), 64'd0);
    stall = 1'b0;
    tick(); tick(); tick();
    chk("b7_cnt1", 64'(count), 64'd1);
    chk("b7_last_pc", 64'(out_pc0), 64'h118);
    chk("b7_valid_single", 64'(out_valid), 64'b01);
    tick();
    chk("b7_drained", 64'(count), 64'd0);

    // T3 single issue (entries at 7, 0, 1)
    stall = 1'b1;
    push(2'b11, 32'h1000, 32'h1004); tick();
    push(2'b01, 32'h1008, 32'h0);    tick();
    push(2'b00, 32'h0, 32'h0);
    chk("t3_cnt3", 64'(count), 64'd3);
    chk("t3_pc0_pre", 64'(out_pc0), 64'h1000);
    stall = 1'b0; issue_one = 1'b1;
    tick();
    issue_one = 1'b0; stall = 1'b1;
    chk("t3_pc0", 64'(out_pc0), 64'h1004);
    chk("t3_pc1", 64'(out_pc1), 64'h1008);
    chk("t3_cnt", 64'(count), 64'd2);
    stall = 1'b0;
    tick();
    chk("t3_drained", 64'(count), 64'd0);

    // T4 wrap: head at 2 -> fill to tail 7, drain so head reaches 7
    stall = 1'b1;
    push(2'b11, 32'h0, 32'h4); tick();
    push(2'b11, 32'h8, 32'hc); tick();
    push(2'b01, 32'h10, 32'h0); tick();
    push(2'b00, 32'h0, 32'h0);
    stall = 1'b0;
    tick(); tick(); tick();
    chk("t4_empty", 64'(count), 64'd0);
    stall = 1'b1;
    push(2'b11, 32'h2000, 32'h2004); tick();
    push(2'b00, 32'h0, 32'h0);
    chk("t4_valid", 64'(out_valid), 64'b11);
    chk("t4_pc0", 64'(out_pc0), 64'h2000);
    chk("t4_pc1", 64'(out_pc1), 64'h2004);
    chk("t4_instr1", 64'(out_instr1), 64'h2005);

    // T5 flush with stall and a push in the same cycle
    push(2'b11, 32'h2008, 32'h200c); tick();
    push(2'b01, 32'h2010, 32'h0);    tick();
    chk("t5_cnt5", 64'(count), 64'd5);
    flush = 1'b1;
    push(2'b11, 32'h3000, 32'h3004);
    tick();
    flush = 1'b0;
    push(2'b00, 32'h0, 32'h0);
    chk("t5_cnt", 64'(count), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_ready", 64'(push_ready), 64'd1);
    stall = 1'b0;
    tick();
    chk("t5_absent", 64'(count), 64'd0);

    // Empty: issue_one has no effect
    issue_one = 1'b1;
    tick();
    issue_one = 1'b0;
    chk("empty_issue_one", 64'(count), 64'd0);

    // T6 steady push/retire at count 3 against a queue model
    stall = 1'b1;
    push(2'b11, 32'h4000, 32'h4004); tick();
    push(2'b01, 32'h4008, 32'h0);    tick();
    model_q.push_back(32'h4000);
    model_q.push_back(32'h4004);
    model_q.push_back(32'h4008);
    stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("t6_pc0", 64'(out_pc0), 64'(model_q[0]));
      chk("t6_pc1", 64'(out_pc1), 64'(model_q[1]));
      chk("t6_instr0", 64'(out_instr0), 64'(model_q[0] + 32'h1));
      push(2'b11, 32'h5000 + 32'(8 * k), 32'h5004 + 32'(8 * k));
      tick();
      void'(model_q.pop_front());
      void'(model_q.pop_front());
      model_q.push_back(32'h5000 + 32'(8 * k));
      model_q.push_back(32'h5004 + 32'(8 * k));
      chk("t6_count", 64'(count), 64'd3);
    end
    push(2'b00, 32'h0, 32'h0);
    chk("t6_tail_pc0", 64'(out_pc0), 64'h5044);
    tick();
    chk("t6_drain1", 64'(count), 64'd1);
    chk("t6_last_pc", 64'(out_pc0), 64'h504c);
    tick();
    chk("t6_drain0", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
